// File: rtl/instruction_prefetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_prefetch_buffer: sequential fetch, in-order prefetch FIFO,    |
// | redirect flush and halt detection. Optional: IPB_PERF_COUNTERS_EN. Rev 1.0|
// +--------------------------------------------------------------------------+
module instruction_prefetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef IPB_PERF_COUNTERS_EN
  ,
  output logic [15:0]              perf_flushed_entries,
  output logic [15:0]              perf_stall_cycles
`endif
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] discard;
  logic [CW-1:0] occ;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          redirect;
  logic          enq;
  logic          deq;

  // Stored entries plus outstanding requests never exceed DEPTH, so the FIFO cannot overflow.
  assign credit_ok       = ({1'b0, occ} + {1'b0, in_flight}) < {1'b0, FULL};
  assign imem_req_valid  = !reset && (state == ST_RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect        = redirect_valid && (state != ST_HALTED);
  assign enq             = imem_resp_valid && !redirect && (discard == '0) && (state == ST_RUN);
  assign out_valid       = (occ != '0);
  assign deq             = out_valid && out_ready;
  assign out_instruction = out_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign out_pc          = out_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign halted          = (state == ST_HALTED);
  assign occupancy       = occ;

  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_instr[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      in_flight <= '0;
      discard   <= '0;
      occ       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      assert (!(enq && (occ == FULL) && !deq));
      in_flight <= in_flight + CW'(req_fire) - CW'(imem_resp_valid);
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (imem_resp_valid && (discard != '0)) discard <= discard - 1'b1;
      if (enq) begin
        wr_ptr  <= wr_ptr + 1'b1;
        resp_pc <= resp_pc + 32'd4;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(enq) - CW'(deq);

      if (enq && (imem_resp_data == HALT_WORD)) state <= ST_DRAIN;
      if ((state == ST_DRAIN) && deq && (out_instruction == HALT_WORD)) state <= ST_HALTED;

      // Every outstanding response except the one arriving now must be thrown away.
      if (redirect) begin
        discard  <= in_flight - CW'(imem_resp_valid);
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
        state    <= ST_RUN;
      end
    end
  end

`ifdef IPB_PERF_COUNTERS_EN
  logic [CW:0]  flush_count;
  logic [16:0]  flush_sum;

  assign flush_count = {1'b0, occ - CW'(deq)} + {1'b0, in_flight - CW'(imem_resp_valid)};
  assign flush_sum   = {1'b0, perf_flushed_entries} + 17'(flush_count);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_flushed_entries <= 16'h0;
      perf_stall_cycles    <= 16'h0;
    end else begin
      if (redirect) perf_flushed_entries <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      if ((state == ST_RUN) && !out_valid && (perf_stall_cycles != 16'hFFFF))
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch_buffer.sv
`default_nettype none
// tb_instruction_prefetch_buffer: directed and random fetch traffic checked
// against a queue-level model of requests, in-flight responses and the FIFO.
module tb_instruction_prefetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_instruction, out_pc;
  logic        halted;
  logic [2:0]  occupancy;
`ifdef IPB_PERF_COUNTERS_EN
  logic [15:0] perf_flushed_entries, perf_stall_cycles;
`endif

  always #5 clock = ~clock;

  instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC), .HALT_WORD(HALT)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .halted(halted), .occupancy(occupancy)
`ifdef IPB_PERF_COUNTERS_EN
    , .perf_flushed_entries(perf_flushed_entries), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit drop; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  req_t        mq[$];
  ent_t        fq[$];
  logic [31:0] m_fetch_pc, halt_addr, salt, hold_addr, tmp;
  bit          m_drain, m_halted, found;
  int          cyc, lat, last_due;
  int unsigned m_flush, m_stall;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == halt_addr) return HALT;
    w = (a * 32'h9E37_79B1) ^ salt;
    if (w == HALT) w = 32'h0000_0013;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(posedge clock); @(posedge clock); #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_halted", halted, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instruction, 0);
    mq.delete(); fq.delete();
    m_fetch_pc = RPC; m_drain = 0; m_halted = 0;
    cyc = 0; last_due = -1; m_flush = 0; m_stall = 0;
    reset = 1'b0;
  endtask

  // One clock cycle: drive memory response, check outputs, advance the model.
  task automatic tick();
    bit   resp, exp_rv, rfire, dfire, redir, run_idle;
    int   due, fsz, msz;
    req_t r;
    ent_t e;
    resp = 0;
    if (mq.size() > 0) resp = (mq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(mq[0].addr) : $urandom;
    #1;
    fsz = fq.size(); msz = mq.size();
    exp_rv = !m_drain && !m_halted && (fsz + msz < DEPTH) && !redirect_valid;
    check("req_valid", imem_req_valid, exp_rv);
    check("req_addr", imem_req_addr, m_fetch_pc);
    check("occupancy", occupancy, fsz);
    check("out_valid", out_valid, fsz > 0);
    check("halted", halted, m_halted);
    if (fsz > 0) begin
      check("out_pc", out_pc, fq[0].pc);
      check("out_instr", out_instruction, fq[0].word);
    end
`ifdef IPB_PERF_COUNTERS_EN
    check("perf_flush", perf_flushed_entries, m_flush[15:0]);
    check("perf_stall", perf_stall_cycles, m_stall[15:0]);
`endif
    rfire    = exp_rv && imem_req_ready;
    dfire    = (fsz > 0) && out_ready;
    redir    = redirect_valid && !m_halted;
    run_idle = !m_drain && !m_halted && (fsz == 0);
    @(posedge clock);
    if (dfire) begin
      e = fq.pop_front();
      if (m_drain && !redir && e.word == HALT) m_halted = 1;
    end
    if (resp) begin
      r = mq.pop_front();
      if (!r.drop && !redir && !m_drain && !m_halted) begin
        e.pc = r.addr; e.word = mem_word(r.addr);
        fq.push_back(e);
        if (e.word == HALT) m_drain = 1;
      end
    end
    if (redir) begin
      m_flush += (fsz - int'(dfire)) + (msz - int'(resp));
      foreach (mq[i]) mq[i].drop = 1'b1;
      fq.delete();
      m_fetch_pc = redirect_target;
      m_drain = 0;
    end
    if (rfire) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = m_fetch_pc; r.due = due; r.drop = 0;
      mq.push_back(r);
      m_fetch_pc += 32'd4;
    end
    if (run_idle) m_stall++;
    cyc++;
    #1;
  endtask

  task automatic random_phase(input int n, input bit near);
    for (int i = 0; i < n; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      tmp = $urandom;
      if (near) redirect_target = tmp & 32'h0000_003C;
      else if (tmp[0]) redirect_target = 32'hFFFF_FFF0 | (tmp & 32'hC);
      else redirect_target = tmp & 32'hFFFF_FFFC;
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    lat = 1; halt_addr = 32'h1; salt = $urandom;
    imem_req_ready = 1'b1; out_ready = 1'b1; redirect_target = 32'h0;
    do_reset();

    // Streaming at latency 1: first entry appears in the third cycle.
    check("first_valid_c0", out_valid, 0); tick();
    check("first_valid_c1", out_valid, 0); tick();
    check("first_valid_c2", out_valid, 1);
    check("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 10; i++) tick();

    // Decode back-pressure fills the buffer and stops requests.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_full_occ", occupancy, 4);
    check("bp_no_req", imem_req_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Redirect at latency 3 with three outstanding, one returning this cycle.
    do_reset(); lat = 3; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 3 && mq[0].due <= cyc) begin
        redirect_valid = 1'b1; redirect_target = 32'h40; tick();
        redirect_valid = 1'b0; found = 1;
      end else tick();
    end
    check("redir_setup", found, 1);
    for (int i = 0; i < 12 && !out_valid; i++) tick();
    check("redir_first_pc", out_pc, 32'h40);
    check("redir_first_instr", out_instruction, mem_word(32'h40));
    for (int i = 0; i < 6; i++) tick();

    // Halt word at 0x8.
    do_reset(); lat = 1; halt_addr = 32'h8;
    for (int i = 0; i < 12; i++) tick();
    check("halt_halted", halted, 1);
    check("halt_no_req", imem_req_valid, 0);
    redirect_valid = 1'b1; redirect_target = 32'h100; tick();
    redirect_valid = 1'b0; tick(); tick();
    check("halt_sticky", halted, 1);
    halt_addr = 32'h1;

    // Memory back-pressure holds the request address.
    do_reset(); lat = 2;
    for (int i = 0; i < 3; i++) tick();
    imem_req_ready = 1'b0; hold_addr = m_fetch_pc;
    for (int i = 0; i < 5; i++) tick();
    check("hold_addr", imem_req_addr, hold_addr);
    check("hold_req_valid", imem_req_valid, 1);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

`ifdef IPB_PERF_COUNTERS_EN
    // Three stored plus one in flight flushed by a redirect.
    do_reset(); lat = 2; out_ready = 1'b0;
    tick(); tick(); tick();
    imem_req_ready = 1'b0; tick(); tick();
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h200; tick();
    redirect_valid = 1'b0;
    check("perf_flush_4", perf_flushed_entries, 16'd4);
    imem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
`endif

    // Random traffic, with wrap-around targets, then with halts reachable.
    do_reset();
    random_phase(400, 1'b0);
    do_reset(); halt_addr = 32'h30;
    random_phase(300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
